// File: rtl/wt_dcache_ship_repl.sv
// wt_dcache_ship_repl
//   SHiP/RRIP replacement controller for the write-through dcache. Tracks
//   per-line {valid, outcome, rrpv, signature}, sends counter-increment
//   updates to the SHCT predictor on hits, and on a fill picks a victim,
//   sends the victim's eviction update and installs the new line with the
//   RRPV the predictor suggests.
//
// Ports
//   clk_i, rst_i            clock, async active-high reset
//   flush_i                 sync clear of all replacement state (same as reset)
//   hit_valid_i/set/way     dcache hit this cycle
//   fill_req_i/set/sig      fill request, held until fill_ack_o
//   fill_ack_o, fill_way_o  1-cycle install pulse and chosen victim way
//   pred_hit_o/_shct_o      predictor hit update (1 cycle after the hit)
//   pred_miss_o/_outcome_o/_miss_shct_o   predictor eviction update
//   pred_shct_o, pred_result_i            predictor lookup (combinational)
//
// Build option
//   WT_DCACHE_SHIP_STATS_EN : adds 32-bit wrapping counters stat_hits_o,
//   stat_fills_o, stat_distant_o, stat_aging_o (cleared on reset/flush).
module wt_dcache_ship_repl #(
  parameter int unsigned NumSets  = 64,
  parameter int unsigned NumWays  = 8,
  parameter int unsigned SigWidth = 14,
  localparam int unsigned SetW    = $clog2(NumSets),
  localparam int unsigned WayW    = $clog2(NumWays)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  input  logic                hit_valid_i,
  input  logic [SetW-1:0]     hit_set_i,
  input  logic [WayW-1:0]     hit_way_i,
  input  logic                fill_req_i,
  input  logic [SetW-1:0]     fill_set_i,
  input  logic [SigWidth-1:0] fill_sig_i,
  output logic                fill_ack_o,
  output logic [WayW-1:0]     fill_way_o,
  output logic                pred_hit_o,
  output logic [SigWidth-1:0] pred_hit_shct_o,
  output logic                pred_miss_o,
  output logic                pred_outcome_o,
  output logic [SigWidth-1:0] pred_miss_shct_o,
  output logic [SigWidth-1:0] pred_shct_o,
  input  logic [1:0]          pred_result_i
`ifdef WT_DCACHE_SHIP_STATS_EN
  ,
  output logic [31:0]         stat_hits_o,
  output logic [31:0]         stat_fills_o,
  output logic [31:0]         stat_distant_o,
  output logic [31:0]         stat_aging_o
`endif
);

  typedef enum logic [1:0] {IDLE, SEARCH, INSTALL} state_e;

  state_e state_q, state_d;

  logic [NumSets-1:0][NumWays-1:0]               valid_q, outcome_q;
  logic [NumSets-1:0][NumWays-1:0][1:0]          rrpv_q;
  logic [NumSets-1:0][NumWays-1:0][SigWidth-1:0] sig_q;

  logic [SetW-1:0]     set_q;
  logic [SigWidth-1:0] fsig_q;
  logic [WayW-1:0]     vway_q;
  logic                pred_hit_q;
  logic [SigWidth-1:0] pred_hit_sig_q;

  logic            in_install, hit_ok, search_stall, sel, age;
  logic            inv_found, far_found;
  logic [WayW-1:0] inv_way, far_way, sel_way;

  assign in_install = (state_q == INSTALL);

  // A hit landing on the way being overwritten this cycle is dropped: the
  // new line owns that slot, so neither state nor predictor see the hit.
  assign hit_ok = hit_valid_i && valid_q[hit_set_i][hit_way_i] &&
                  !(in_install && hit_set_i == set_q && hit_way_i == vway_q);

  // A hit into the set being searched is applied first; the search decision
  // is postponed one cycle so it sees the hit's RRPV/outcome update.
  assign search_stall = (state_q == SEARCH) && hit_ok && (hit_set_i == set_q);

  // Lowest-index invalid way, and lowest-index valid way at distant RRPV.
  // Descending scan so the lowest index is the last (winning) assignment.
  always_comb begin
    inv_found = 1'b0;
    inv_way   = '0;
    far_found = 1'b0;
    far_way   = '0;
    for (int w = NumWays - 1; w >= 0; w--) begin
      if (!valid_q[set_q][WayW'(w)]) begin
        inv_found = 1'b1;
        inv_way   = WayW'(w);
      end
      if (valid_q[set_q][WayW'(w)] && rrpv_q[set_q][WayW'(w)] == 2'd3) begin
        far_found = 1'b1;
        far_way   = WayW'(w);
      end
    end
  end

  assign sel     = (state_q == SEARCH) && !search_stall && (inv_found || far_found);
  assign sel_way = inv_found ? inv_way : far_way;
  assign age     = (state_q == SEARCH) && !search_stall && !inv_found && !far_found;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (fill_req_i) state_d = SEARCH;
      SEARCH:  if (sel)        state_d = INSTALL;
      INSTALL:                 state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= IDLE;
      set_q          <= '0;
      fsig_q         <= '0;
      vway_q         <= '0;
      pred_hit_q     <= 1'b0;
      pred_hit_sig_q <= '0;
    end else if (flush_i) begin
      state_q        <= IDLE;
      set_q          <= '0;
      fsig_q         <= '0;
      vway_q         <= '0;
      pred_hit_q     <= 1'b0;
      pred_hit_sig_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && fill_req_i) begin
        set_q  <= fill_set_i;
        fsig_q <= fill_sig_i;
      end
      if (sel) vway_q <= sel_way;
      pred_hit_q     <= hit_ok;
      pred_hit_sig_q <= hit_ok ? sig_q[hit_set_i][hit_way_i] : '0;
    end
  end

  // Per-line replacement state. Install is written last so it overrides
  // anything else aimed at the victim in the same cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q   <= '0;
      outcome_q <= '0;
      rrpv_q    <= '1;
      sig_q     <= '0;
    end else if (flush_i) begin
      valid_q   <= '0;
      outcome_q <= '0;
      rrpv_q    <= '1;
      sig_q     <= '0;
    end else begin
      if (hit_ok) begin
        rrpv_q[hit_set_i][hit_way_i]    <= 2'd0;
        outcome_q[hit_set_i][hit_way_i] <= 1'b1;
      end
      // Aging never coincides with a hit to this set (search_stall).
      if (age) begin
        for (int w = 0; w < NumWays; w++) begin
          if (valid_q[set_q][WayW'(w)] && rrpv_q[set_q][WayW'(w)] != 2'd3)
            rrpv_q[set_q][WayW'(w)] <= rrpv_q[set_q][WayW'(w)] + 2'd1;
        end
      end
      if (in_install) begin
        valid_q[set_q][vway_q]   <= 1'b1;
        outcome_q[set_q][vway_q] <= 1'b0;
        sig_q[set_q][vway_q]     <= fsig_q;
        rrpv_q[set_q][vway_q]    <= (pred_result_i == 2'd0) ? 2'd3 : 2'd2;
      end
    end
  end

  assign fill_ack_o       = in_install;
  assign fill_way_o       = in_install ? vway_q : '0;
  assign pred_miss_o      = in_install && valid_q[set_q][vway_q];
  assign pred_outcome_o   = in_install && outcome_q[set_q][vway_q];
  assign pred_miss_shct_o = in_install ? sig_q[set_q][vway_q] : '0;
  assign pred_shct_o      = (state_q == SEARCH || in_install) ? fsig_q : '0;
  assign pred_hit_o       = pred_hit_q;
  assign pred_hit_shct_o  = pred_hit_sig_q;

`ifdef WT_DCACHE_SHIP_STATS_EN
  logic [31:0] hits_q, fills_q, distant_q, aging_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hits_q    <= '0;
      fills_q   <= '0;
      distant_q <= '0;
      aging_q   <= '0;
    end else if (flush_i) begin
      hits_q    <= '0;
      fills_q   <= '0;
      distant_q <= '0;
      aging_q   <= '0;
    end else begin
      if (pred_hit_q)                           hits_q    <= hits_q + 32'd1;
      if (in_install)                           fills_q   <= fills_q + 32'd1;
      if (in_install && pred_result_i == 2'd0)  distant_q <= distant_q + 32'd1;
      if (age)                                  aging_q   <= aging_q + 32'd1;
    end
  end

  assign stat_hits_o    = hits_q;
  assign stat_fills_o   = fills_q;
  assign stat_distant_o = distant_q;
  assign stat_aging_o   = aging_q;
`endif

endmodule

// File: tb/tb_wt_dcache_ship_repl.sv
// Bench for wt_dcache_ship_repl: table-driven fill vectors, hand-written
// corner sequences and a randomized phase checked against a per-line
// behavioural model of the SHiP/RRIP rules.
module tb_wt_dcache_ship_repl;

  logic        clk = 1'b0;
  logic        rst_i, flush_i;
  logic        hit_valid_i;
  logic [5:0]  hit_set_i;
  logic [2:0]  hit_way_i;
  logic        fill_req_i;
  logic [5:0]  fill_set_i;
  logic [13:0] fill_sig_i;
  logic        fill_ack_o;
  logic [2:0]  fill_way_o;
  logic        pred_hit_o;
  logic [13:0] pred_hit_shct_o;
  logic        pred_miss_o;
  logic        pred_outcome_o;
  logic [13:0] pred_miss_shct_o;
  logic [13:0] pred_shct_o;
  logic [1:0]  pred_result_i;

  always #5 clk = ~clk;

  wt_dcache_ship_repl dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .hit_valid_i(hit_valid_i), .hit_set_i(hit_set_i), .hit_way_i(hit_way_i),
    .fill_req_i(fill_req_i), .fill_set_i(fill_set_i), .fill_sig_i(fill_sig_i),
    .fill_ack_o(fill_ack_o), .fill_way_o(fill_way_o),
    .pred_hit_o(pred_hit_o), .pred_hit_shct_o(pred_hit_shct_o),
    .pred_miss_o(pred_miss_o), .pred_outcome_o(pred_outcome_o),
    .pred_miss_shct_o(pred_miss_shct_o), .pred_shct_o(pred_shct_o),
    .pred_result_i(pred_result_i)
  );

  int passed = 0;
  int total  = 0;

  // Reference model: one record per line.
  bit m_valid [64][8];
  bit m_out   [64][8];
  int m_rrpv  [64][8];
  int m_sig   [64][8];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  function automatic void model_clear();
    for (int s = 0; s < 64; s++)
      for (int w = 0; w < 8; w++) begin
        m_valid[s][w] = 0; m_out[s][w] = 0; m_rrpv[s][w] = 3; m_sig[s][w] = 0;
      end
  endfunction

  // Victim choice from the priority rules; each fruitless pass ages the set
  // and costs one more cycle on top of the 2-cycle minimum.
  function automatic void model_fill(input int s, input int sig, input int pres,
                                     output int way, output int lat, output int miss,
                                     output int msig, output int outc);
    lat = 2;
    way = -1;
    for (int pass = 0; pass < 5 && way < 0; pass++) begin
      for (int w = 0; w < 8 && way < 0; w++) if (!m_valid[s][w]) way = w;
      for (int w = 0; w < 8 && way < 0; w++) if (m_rrpv[s][w] == 3) way = w;
      if (way < 0) begin
        for (int w = 0; w < 8; w++) if (m_rrpv[s][w] < 3) m_rrpv[s][w]++;
        lat++;
      end
    end
    miss = m_valid[s][way];
    msig = m_sig[s][way];
    outc = m_out[s][way];
    m_valid[s][way] = 1;
    m_out[s][way]   = 0;
    m_sig[s][way]   = sig;
    m_rrpv[s][way]  = (pres == 0) ? 3 : 2;
  endfunction

  // Drive a fill at a negedge, wait for the ack, optionally fire a hit at
  // the victim during the install cycle; returns with the FSM back in IDLE.
  task automatic do_fill(input string tag, input int s, input int sig, input int pres,
                         input bit hitv, input int hv_way,
                         output int way, output int lat, output int miss,
                         output int msig, output int outc, output int shct);
    bit got = 0;
    way = 0; lat = 99; miss = 0; msig = 0; outc = 0; shct = 0;
    fill_req_i = 1; fill_set_i = 6'(s); fill_sig_i = 14'(sig); pred_result_i = 2'(pres);
    for (int n = 1; n <= 8 && !got; n++) begin
      @(negedge clk);
      if (fill_ack_o) begin
        got = 1; lat = n; way = fill_way_o; miss = pred_miss_o;
        msig = pred_miss_shct_o; outc = pred_outcome_o; shct = pred_shct_o;
      end
    end
    fill_req_i = 0;
    chk({tag, "_ack"}, 32'(got), 1);
    if (hitv) begin
      hit_valid_i = 1; hit_set_i = 6'(s); hit_way_i = 3'(hv_way);
    end
    @(negedge clk);
    hit_valid_i = 0;
    if (hitv) chk({tag, "_hitdrop"}, 32'(pred_hit_o), 0);
  endtask

  task automatic fill_chk(input string tag, input int s, input int sig, input int pres,
                          input bit hitv, output int ew, output int gw, output int gout);
    int el, em, es, eo, gl, gm, gs, gsh;
    model_fill(s, sig, pres, ew, el, em, es, eo);
    do_fill(tag, s, sig, pres, hitv, ew, gw, gl, gm, gs, gout, gsh);
    chk({tag, "_way"}, gw, ew);
    chk({tag, "_lat"}, gl, el);
    chk({tag, "_miss"}, gm, em);
    chk({tag, "_msig"}, gs, es);
    chk({tag, "_outc"}, gout, eo);
    chk({tag, "_shct"}, gsh, sig);
  endtask

  task automatic do_hit(input string tag, input int s, input int w);
    int eh = m_valid[s][w];
    int es = eh ? m_sig[s][w] : 0;
    if (eh) begin m_rrpv[s][w] = 0; m_out[s][w] = 1; end
    hit_valid_i = 1; hit_set_i = 6'(s); hit_way_i = 3'(w);
    @(negedge clk);
    hit_valid_i = 0;
    chk({tag, "_v"}, 32'(pred_hit_o), eh);
    chk({tag, "_sig"}, 32'(pred_hit_shct_o), es);
  endtask

  typedef struct {
    int set; int sig; int pres;
    int way; int lat; int miss; int msig; int outc;
  } vec_t;

  initial begin
    vec_t tbl[9];
    int ew, gw, go, d0, d1, d2, d3, d4;

    for (int i = 0; i < 8; i++) tbl[i] = '{0, 'h15, 1, i, 2, 0, 0, 0};
    tbl[8] = '{0, 'h33, 1, 0, 3, 1, 'h15, 0};

    rst_i = 1; flush_i = 0; hit_valid_i = 0; hit_set_i = 0; hit_way_i = 0;
    fill_req_i = 0; fill_set_i = 0; fill_sig_i = 0; pred_result_i = 0;
    model_clear();
    repeat (2) @(negedge clk);
    rst_i = 0;
    @(negedge clk);
    chk("rst_ack", 32'(fill_ack_o), 0);
    chk("rst_way", 32'(fill_way_o), 0);
    chk("rst_phit", 32'(pred_hit_o), 0);
    chk("rst_pmiss", 32'(pred_miss_o), 0);
    chk("rst_shct", 32'(pred_shct_o), 0);
    do_hit("hit_invalid", 0, 0);

    // Fill set 0 in way order, then one aging round evicting way 0.
    for (int i = 0; i < 9; i++) begin
      int gl, gm, gs, gsh;
      model_fill(tbl[i].set, tbl[i].sig, tbl[i].pres, d0, d1, d2, d3, d4);
      do_fill($sformatf("tbl%0d", i), tbl[i].set, tbl[i].sig, tbl[i].pres, 0, 0,
              gw, gl, gm, gs, go, gsh);
      chk($sformatf("tbl%0d_way", i), gw, tbl[i].way);
      chk($sformatf("tbl%0d_lat", i), gl, tbl[i].lat);
      chk($sformatf("tbl%0d_miss", i), gm, tbl[i].miss);
      chk($sformatf("tbl%0d_msig", i), gs, tbl[i].msig);
      chk($sformatf("tbl%0d_outc", i), go, tbl[i].outc);
      chk($sformatf("tbl%0d_shct", i), gsh, tbl[i].sig);
    end

    // Hit update latency and outcome propagation to eviction (set 1).
    for (int i = 0; i < 8; i++) fill_chk($sformatf("s1f%0d", i), 1, 'h27 + i, 1, 0, ew, gw, go);
    do_hit("t3_hit", 1, 3);
    // Distant install: next fill reuses it without aging.
    fill_chk("t4a", 1, 'h100, 0, 0, ew, gw, go);
    fill_chk("t4b", 1, 'h101, 1, 0, ew, gw, go);
    chk("t4_reuse_way", gw, 0);
    ew = -1;
    for (int k = 0; k < 30 && ew != 3; k++) fill_chk("t3ev", 1, 'h200 + k, 1, 0, ew, gw, go);
    chk("t3_evict_way", gw, 3);
    chk("t3_evict_outc", go, 1);

    // Hit to the victim during install is dropped (set 3).
    for (int i = 0; i < 8; i++) fill_chk($sformatf("s3f%0d", i), 3, 'h300 + i, 1, 0, ew, gw, go);
    fill_chk("t5", 3, 'h3AB, 1, 1, ew, gw, go);
    do_hit("t5_after", 3, ew);

    // Flush in the middle of a search.
    for (int i = 0; i < 8; i++) fill_chk($sformatf("s2f%0d", i), 2, 'h400 + i, 1, 0, ew, gw, go);
    fill_req_i = 1; fill_set_i = 2; fill_sig_i = 14'h0555; pred_result_i = 1;
    @(negedge clk);
    flush_i = 1; fill_req_i = 0;
    @(negedge clk);
    flush_i = 0;
    chk("t6_noack0", 32'(fill_ack_o), 0);
    chk("t6_shct", 32'(pred_shct_o), 0);
    @(negedge clk);
    chk("t6_noack1", 32'(fill_ack_o), 0);
    model_clear();
    fill_chk("t6_refill", 2, 'h0555, 1, 0, ew, gw, go);
    chk("t6_way0", gw, 0);

    // Randomized traffic over a few sets so they fill up and age.
    for (int k = 0; k < 300; k++) begin
      int s = $urandom_range(4, 7);
      if ($urandom_range(0, 1) == 0)
        fill_chk("rnd_fill", s, $urandom_range(0, 16383), $urandom_range(0, 3), 0, ew, gw, go);
      else
        do_hit("rnd_hit", s, $urandom_range(0, 7));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
